digit_display_scanner: RTL and testbench
========================================

# digit_display_scanner

Read-side counterpart of the keypad entry path. It takes the four stored 4-bit digit registers, snapshots them on a load strobe and time-multiplexes them onto a 4-digit common-anode seven-segment display. It decodes each BCD digit to segment drive, with optional leading-zero blanking and a dead-time between digits to suppress ghosting.

## Interface
Parameters:
- PRESCALE, 1000: clock cycles per digit slot (blank phase plus on phase); must be > BLANK_CYCLES + 1.
- BLANK_CYCLES, 16: dead-time cycles at the start of each slot; must be ≥ 1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scan enable; low forces IDLE.
- load  in  1  snapshot strobe; latches all four digit inputs on the edge where load=1.
- lzb_en  in  1  leading-zero blanking enable.
- digit_in1  in  4  most-significant digit (BCD).
- digit_in2  in  4  digit 2.
- digit_in3  in  4  digit 3.
- digit_in4  in  4  least-significant digit.
- seg_n  out  7  segments, active-low; bit0=a … bit6=g.
- an_n  out  4  anode enables, active-low; an_n[0] = digit_in1 position.
- scan_idx  out  2  index of the current slot.
- frame_done  out  1  one-cycle pulse on the last on-cycle of slot 3.

## Operation
- Shadow registers sh1..sh4 (4 bits each) load from digit_in1..4 when load=1. Otherwise they hold.
- States:
  - IDLE: enable=0. an_n=1111, seg_n=7F, counter=0, idx=0.
  - BLANK: an_n=1111 for BLANK_CYCLES cycles.
  - ON: an_n[idx]=0, the others 1, for PRESCALE−BLANK_CYCLES cycles.
- Transitions:
  - IDLE→BLANK on enable=1.
  - BLANK→ON when the counter reaches BLANK_CYCLES−1.
  - ON→BLANK when the counter reaches PRESCALE−1; idx increments mod 4 and the counter clears.
  - Any state→IDLE on enable=0, taking effect at the next edge.
- seg_n is registered at the BLANK→ON edge from sh[idx] and held constant for the whole ON phase. A load during ON does not alter the lit digit.
- Decode, active-low (0–9): 40, 79, 24, 30, 19, 12, 02, 78, 00, 10. Values 10–15 display a dash (3F). Blank is 7F.
- Leading-zero blanking (lzb_en=1): a digit at position k∈{1,2,3} shows blank when it and all more-significant shadow digits are 0. Digit 4 is never blanked. A non-BCD digit counts as non-zero.
- seg_n=7F whenever an_n=1111.

## Timing
- Reset values: an_n=1111, seg_n=7F, scan_idx=0, frame_done=0, sh1..sh4=0, counter=0, state=IDLE.
- rst has priority over enable and load. Asserting rst mid-slot blanks the outputs at the next edge.
- Load latency is one edge into the shadow registers. The new value first appears at the next BLANK→ON edge of the corresponding slot.
- Load coincident with BLANK→ON of the same idx: the pre-load shadow value is displayed. This is old-value semantics, with no bypass.
- Frame period is 4·PRESCALE cycles. frame_done is high for exactly one cycle per frame and is never asserted in IDLE.
- enable dropping mid-frame aborts the frame. Re-enabling restarts at BLANK with idx=0.

## Structure
- Package digit_disp_pkg holds:
  - state encoding (IDLE, BLANK, ON);
  - the SEG_0..SEG_9 constants;
  - SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
- Sub-module bcd_to_seg7 is a purely combinational decode of 4-bit to 7-bit active-low. It is shared with any future display use.
- The top holds the shadow registers, the slot counter (width $clog2(PRESCALE)), idx, the FSM, the LZB logic and the output registers.

## Test plan
All scenarios use PRESCALE=8 and BLANK_CYCLES=2.
- Reset and scan: release rst with enable=1, then load 1,2,3,4.
  - Required response: an_n cycles 1110→1101→1011→0111 in 6-cycle ON windows separated by 2 blank cycles.
  - seg_n is 79, 24, 30, 19 in turn; frame_done pulses every 32 cycles.
- Leading-zero blanking: load 0,0,0,7 with lzb_en=1.
  - Required response: seg_n=7F in slots 0–2 and 78 in slot 3.
  - With lzb_en=0, slots 0–2 show 40.
- Invalid digit: load 0,C,0,5 with lzb_en=1.
  - Required response: slot 0 blank, slot 1 shows 3F, slot 2 shows 40, slot 3 shows 12.
- Load at slot boundary: pulse load with digit_in1=9 on the exact BLANK→ON edge of slot 0.
  - Required response: the old digit stays displayed for that slot; 10 appears from the next frame's slot 0.
- Enable drop mid-frame: drop enable during ON of slot 2, then re-enable.
  - Required response: next edge gives an_n=1111 and seg_n=7F with no frame_done.
  - On re-enable, 2 blank cycles, then an_n=1110.
- Reset mid-operation: assert rst during slot 1 ON.
  - Required response: next edge gives all outputs and shadow registers at their reset values.
  - After release, display shows 40 in all slots, since the shadows are 0 and lzb_en=0.

Source files
------------

// File: rtl/digit_disp_pkg.sv
// Shared encodings for the seven-segment digit display path:
// scanner states and active-low segment patterns (bit0=a .. bit6=g).
package digit_disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } state_e;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decode; non-BCD codes show a dash.
module bcd_to_seg7
   import digit_disp_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_n_o
);

   always_comb begin
      seg_n_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_n_o = SEG_0;
         4'd1:    seg_n_o = SEG_1;
         4'd2:    seg_n_o = SEG_2;
         4'd3:    seg_n_o = SEG_3;
         4'd4:    seg_n_o = SEG_4;
         4'd5:    seg_n_o = SEG_5;
         4'd6:    seg_n_o = SEG_6;
         4'd7:    seg_n_o = SEG_7;
         4'd8:    seg_n_o = SEG_8;
         4'd9:    seg_n_o = SEG_9;
         default: seg_n_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/digit_display_scanner.sv
// Snapshots four BCD digits and time-multiplexes them onto a 4-digit
// common-anode display with per-slot dead-time and optional leading-zero blanking.
module digit_display_scanner
   import digit_disp_pkg::*;
#(
   parameter int PRESCALE     = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       load,
   input  logic       lzb_en,
   input  logic [3:0] digit_in1,
   input  logic [3:0] digit_in2,
   input  logic [3:0] digit_in3,
   input  logic [3:0] digit_in4,
   output logic [6:0] seg_n,
   output logic [3:0] an_n,
   output logic [1:0] scan_idx,
   output logic       frame_done
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] DONE_AT    = CNT_W'(PRESCALE - 2);

   logic [3:0]       din [4];
   logic [3:0]       sh_q [4];
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       idx_q;
   logic [3:0]       an_n_q;
   logic [6:0]       seg_n_q;
   logic             frame_done_q;
   logic [2:0]       zero_flag;
   logic [3:0]       lead_zero;
   logic [6:0]       dec_seg;
   logic [6:0]       seg_on_d;

   assign din[0] = digit_in1;
   assign din[1] = digit_in2;
   assign din[2] = digit_in3;
   assign din[3] = digit_in4;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_shadow
         always_ff @(posedge clk) begin
            if (rst)
               sh_q[gi] <= 4'd0;
            else if (load)
               sh_q[gi] <= din[gi];
         end
      end

      // A position is a leading zero only if it and every more-significant digit are 0.
      for (gi = 0; gi < 3; gi++) begin : g_lzb
         assign zero_flag[gi] = (sh_q[gi] == 4'd0);
         assign lead_zero[gi] = &zero_flag[gi:0];
      end
   endgenerate

   assign lead_zero[3] = 1'b0;

   bcd_to_seg7 u_dec (
      .bcd_i   (sh_q[idx_q]),
      .seg_n_o (dec_seg)
   );

   assign seg_on_d = (lzb_en && lead_zero[idx_q]) ? SEG_BLANK : dec_seg;

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         idx_q        <= 2'd0;
         an_n_q       <= 4'hF;
         seg_n_q      <= SEG_BLANK;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_BLANK;
               cnt_q   <= '0;
               idx_q   <= 2'd0;
               an_n_q  <= 4'hF;
               seg_n_q <= SEG_BLANK;
            end
            ST_BLANK: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == BLANK_LAST) begin
                  state_q <= ST_ON;
                  an_n_q  <= ~(4'b0001 << idx_q);
                  seg_n_q <= seg_on_d;
               end
            end
            ST_ON: begin
               if (cnt_q == ON_LAST) begin
                  state_q <= ST_BLANK;
                  cnt_q   <= '0;
                  idx_q   <= idx_q + 2'd1;
                  an_n_q  <= 4'hF;
                  seg_n_q <= SEG_BLANK;
               end else begin
                  cnt_q        <= cnt_q + 1'b1;
                  frame_done_q <= (idx_q == 2'd3) && (cnt_q == DONE_AT);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               idx_q   <= 2'd0;
               an_n_q  <= 4'hF;
               seg_n_q <= SEG_BLANK;
            end
         endcase
      end
   end

   assign seg_n      = seg_n_q;
   assign an_n       = an_n_q;
   assign scan_idx   = idx_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_display_scanner.sv
// Directed bench for digit_display_scanner with PRESCALE=8, BLANK_CYCLES=2:
// every scenario is checked cycle by cycle against hand-computed slot patterns.
module tb_digit_display_scanner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       load = 1'b0;
   logic       lzb_en = 1'b0;
   logic [3:0] digit_in1 = 4'd0;
   logic [3:0] digit_in2 = 4'd0;
   logic [3:0] digit_in3 = 4'd0;
   logic [3:0] digit_in4 = 4'd0;
   logic [6:0] seg_n;
   logic [3:0] an_n;
   logic [1:0] scan_idx;
   logic       frame_done;

   int errors = 0;
   int checks = 0;

   digit_display_scanner #(.PRESCALE(8), .BLANK_CYCLES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load),
      .lzb_en     (lzb_en),
      .digit_in1  (digit_in1),
      .digit_in2  (digit_in2),
      .digit_in3  (digit_in3),
      .digit_in4  (digit_in4),
      .seg_n      (seg_n),
      .an_n       (an_n),
      .scan_idx   (scan_idx),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts at the sample right after the edge that enters BLANK of slot 0.
   // segs = {slot3, slot2, slot1, slot0}; digs = {d1, d2, d3, d4}.
   task automatic check_frame(input string name, input bit do_ld, input int ld_n,
                              input logic [15:0] digs, input logic [27:0] segs);
      int slot;
      int c;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_fd;
      int         err0;
      err0 = errors;
      for (int n = 0; n < 32; n++) begin
         slot = n / 8;
         c    = n % 8;
         if (do_ld && n == ld_n) begin
            load      = 1'b1;
            digit_in1 = digs[15:12];
            digit_in2 = digs[11:8];
            digit_in3 = digs[7:4];
            digit_in4 = digs[3:0];
         end
         exp_an  = (c < 2) ? 4'hF : ~(4'b0001 << slot);
         exp_seg = (c < 2) ? 7'h7F : segs[slot*7 +: 7];
         exp_fd  = (n == 31);
         checks++;
         if (an_n !== exp_an) begin
            errors++;
            $display("FAIL %s an_n n=%0d: got %h expected %h", name, n, an_n, exp_an);
         end
         checks++;
         if (seg_n !== exp_seg) begin
            errors++;
            $display("FAIL %s seg_n n=%0d: got %h expected %h", name, n, seg_n, exp_seg);
         end
         checks++;
         if (scan_idx !== 2'(slot)) begin
            errors++;
            $display("FAIL %s scan_idx n=%0d: got %0d expected %0d", name, n, scan_idx, slot);
         end
         checks++;
         if (frame_done !== exp_fd) begin
            errors++;
            $display("FAIL %s frame_done n=%0d: got %b expected %b", name, n, frame_done, exp_fd);
         end
         step();
         if (do_ld && n == ld_n) load = 1'b0;
      end
      $display("frame %s segs=%h errors_in_frame=%0d", name, segs, errors - err0);
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (an_n !== 4'hF || seg_n !== 7'h7F || scan_idx !== 2'd0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL %s: got an_n=%h seg_n=%h idx=%0d fd=%b expected an_n=f seg_n=7f idx=0 fd=0",
                  name, an_n, seg_n, scan_idx, frame_done);
      end
   endtask

   task automatic test_reset();
      step();
      step();
      check_idle("reset_values");
      enable = 1'b1;
      load   = 1'b1;
      digit_in1 = 4'd8;
      step();
      check_idle("reset_priority");
      load = 1'b0;
      rst  = 1'b0;
      step();
      $display("reset released, scanning");
   endtask

   task automatic test_scan();
      check_frame("scan_load", 1'b1, 0, 16'h1234, {7'h19, 7'h30, 7'h24, 7'h79});
      check_frame("scan_repeat", 1'b0, 0, 16'h0000, {7'h19, 7'h30, 7'h24, 7'h79});
   endtask

   task automatic test_lzb();
      lzb_en = 1'b1;
      check_frame("lzb_on", 1'b1, 0, 16'h0007, {7'h78, 7'h7F, 7'h7F, 7'h7F});
      lzb_en = 1'b0;
      check_frame("lzb_off", 1'b0, 0, 16'h0000, {7'h78, 7'h40, 7'h40, 7'h40});
   endtask

   task automatic test_invalid();
      lzb_en = 1'b1;
      check_frame("invalid_digit", 1'b1, 0, 16'h0C05, {7'h12, 7'h40, 7'h3F, 7'h7F});
   endtask

   task automatic test_load_boundary();
      lzb_en = 1'b0;
      check_frame("load_at_on_edge", 1'b1, 1, 16'h9C05, {7'h12, 7'h40, 7'h3F, 7'h40});
      check_frame("load_next_frame", 1'b0, 0, 16'h0000, {7'h12, 7'h40, 7'h3F, 7'h10});
   endtask

   task automatic test_enable_drop();
      for (int i = 0; i < 20; i++) step();
      checks++;
      if (an_n !== 4'b1011 || seg_n !== 7'h40) begin
         errors++;
         $display("FAIL drop_pre: got an_n=%h seg_n=%h expected an_n=b seg_n=40", an_n, seg_n);
      end
      enable = 1'b0;
      step();
      check_idle("drop_next_edge");
      for (int i = 0; i < 4; i++) begin
         step();
         check_idle("drop_idle_hold");
      end
      enable = 1'b1;
      step();
      check_frame("reenable", 1'b0, 0, 16'h0000, {7'h12, 7'h40, 7'h3F, 7'h10});
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 12; i++) step();
      checks++;
      if (an_n !== 4'b1101 || seg_n !== 7'h3F) begin
         errors++;
         $display("FAIL rst_mid_pre: got an_n=%h seg_n=%h expected an_n=d seg_n=3f", an_n, seg_n);
      end
      rst = 1'b1;
      step();
      check_idle("rst_mid_edge");
      rst = 1'b0;
      step();
      check_frame("after_rst_mid", 1'b0, 0, 16'h0000, {7'h40, 7'h40, 7'h40, 7'h40});
   endtask

   initial begin
      #1;
      test_reset();
      test_scan();
      test_lzb();
      test_invalid();
      test_load_boundary();
      test_enable_drop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
